// File: rtl/tristate_rx.sv
// Receive side of a shared tristate pin: turnaround guard, 2-flop sync, deglitch filter.
// Outputs registered; oe=1 forces DRIVE and suppresses all pulses on that edge.
module tristate_rx #(
  parameter int TURN_CYCLES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  input  logic oe,
  output logic rx_data,
  output logic rx_valid,
  output logic rx_rise,
  output logic rx_fall,
  output logic rx_active
);

  localparam int MAXV = (TURN_CYCLES > FILTER_LEN) ? TURN_CYCLES : FILTER_LEN;
  localparam int W    = $clog2(MAXV + 1);
  localparam logic [W-1:0] TURN_LAST = W'(TURN_CYCLES - 1);
  localparam logic [W-1:0] FILT_LAST = W'(FILTER_LEN - 1);
  localparam logic [W-1:0] FILL_LAST = W'(1);

  typedef enum logic [1:0] {DRIVE, TURN, FILL, RECV} state_t;

  state_t       state;
  logic         sync1, sync2;
  logic [W-1:0] timer;
  logic [W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DRIVE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      timer     <= '0;
      fcnt      <= '0;
      rx_data   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_rise   <= 1'b0;
      rx_fall   <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      sync1    <= pad_in;
      sync2    <= sync1;
      rx_valid <= 1'b0;
      rx_rise  <= 1'b0;
      rx_fall  <= 1'b0;
      // Local driver owns the pin: abandon whatever was in progress.
      if (oe) begin
        state     <= DRIVE;
        timer     <= '0;
        fcnt      <= '0;
        rx_active <= 1'b0;
      end else begin
        case (state)
          DRIVE: begin
            state <= TURN;
            timer <= '0;
          end
          TURN: begin
            if (timer == TURN_LAST) begin
              state <= FILL;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          // Two cycles so both sync stages hold post-turnaround samples.
          FILL: begin
            if (timer == FILL_LAST) begin
              state     <= RECV;
              timer     <= '0;
              rx_data   <= sync2;
              rx_valid  <= 1'b1;
              rx_active <= 1'b1;
              fcnt      <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          RECV: begin
            if (sync2 != rx_data) begin
              if (fcnt == FILT_LAST) begin
                rx_data  <= sync2;
                rx_valid <= 1'b1;
                rx_rise  <= sync2;
                rx_fall  <= ~sync2;
                fcnt     <= '0;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end else begin
              fcnt <= '0;
            end
          end
          default: state <= DRIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tristate_rx.sv
// Directed vector bench for tristate_rx with default parameters.
module tb_tristate_rx;

  logic clk = 1'b0;
  logic rst_n, pad_in, oe;
  logic rx_data, rx_valid, rx_rise, rx_fall, rx_active;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic pad;
    logic oe;
    logic d;
    logic v;
    logic r;
    logic f;
    logic a;
  } vec_t;

  vec_t vq[$];

  tristate_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pad_in   (pad_in),
    .oe       (oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rise  (rx_rise),
    .rx_fall  (rx_fall),
    .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  function automatic void add(logic pad, logic o, logic d, logic v, logic r, logic f, logic a);
    vec_t x;
    x.pad = pad; x.oe = o; x.d = d; x.v = v; x.r = r; x.f = f; x.a = a;
    vq.push_back(x);
  endfunction

  task automatic chk(string name, int idx, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic d, logic v, logic r, logic f, logic a);
    chk("rx_data", idx, rx_data, d);
    chk("rx_valid", idx, rx_valid, v);
    chk("rx_rise", idx, rx_rise, r);
    chk("rx_fall", idx, rx_fall, f);
    chk("rx_active", idx, rx_active, a);
  endtask

  // Called at a negedge: drive, clock once, check just after the edge, return at next negedge.
  task automatic apply(int i);
    pad_in = vq[i].pad;
    oe     = vq[i].oe;
    @(posedge clk);
    #1;
    chk_all(i, vq[i].d, vq[i].v, vq[i].r, vq[i].f, vq[i].a);
    @(negedge clk);
  endtask

  initial begin
    // Fields: pad, oe | expected data, valid, rise, fall, active
    // Entry from reset: active after the 5th edge, loads 1 with no rise pulse
    repeat (4) add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    // Long low: accepted 4 edges after first sync capture
    repeat (4) add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 1);
    repeat (5) add(0, 0, 0, 0, 0, 0, 1);
    repeat (4) add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    // 2-cycle glitch rejected
    repeat (2) add(0, 0, 1, 0, 0, 0, 1);
    repeat (4) add(1, 0, 1, 0, 0, 0, 1);
    // 3-cycle low accepted: fall then rise
    repeat (3) add(0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 1);
    repeat (2) add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    // oe held 5 cycles with pad toggling, then re-entry loads fresh 0 without a fall pulse
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0);
    repeat (4) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    // oe pulse during TURN restarts the turnaround
    add(0, 1, 0, 0, 0, 0, 0);
    repeat (2) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    repeat (4) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    // Return to rx_data=1 before the mid-run reset
    repeat (4) add(1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    // After mid-run reset release
    repeat (4) add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1);

    rst_n  = 1'b0;
    oe     = 1'b0;
    pad_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) apply(i);

    // Asynchronous reset between edges while in RECV with rx_data=1
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(-2, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 64; i < vq.size(); i++) apply(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
